freq_gen_module: RTL and testbench

- Programmable square-wave generator: the transmit-side counterpart of the team's frequency meter.
- Synthesises `clk_out` at a requested integer frequency in Hz from `clk_base`, using a fractional (Bresenham-style) accumulator. The long-term average frequency is exact.
- Drives the meter's `clk_in` for self-test and calibration.
- Sits beside the meter on the same `clk_base` domain and is configured over a one-cycle write strobe.

---
 rtl/freq_gen_module.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_freq_gen_module.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gen_module.sv
// -----------------------------------------------------------------------------
// freq_gen_module
//
// Programmable square-wave generator, the transmit-side partner of the
// frequency meter. A fractional (Bresenham-style) accumulator produces clk_out
// at an integer frequency of freq_set Hz from a clk_base of freq_base Hz. The
// long-term average frequency is exact. Each half-period is either the floor
// or the ceiling of freq_base/(2*freq_set) clk_base cycles.
//
// Optional feature macro: FREQ_GEN_BURST_EN
//   defined   : a nonzero burst_len stops generation after that many periods
//               and pulses done.
//   undefined : burst_len is ignored, done is tied 0, generation is continuous.
//
// Parameters
//   W          width of frequency words and of the period counter
//
// Ports
//   clk_base   reference clock; everything runs on its rising edge
//   reset      asynchronous, active-high reset
//   freq_wr    one-cycle write strobe for freq_set / freq_base / burst_len
//   freq_set   requested output frequency in Hz (0 = stop)
//   freq_base  frequency of clk_base in Hz
//   burst_len  periods to emit in burst mode (0 = continuous)
//   clk_out    generated square wave
//   busy       high while generating
//   upd        one-cycle pulse when a written frequency takes effect
//   err        one-cycle pulse when a write is rejected
//   done       one-cycle pulse at burst completion
//   per_cnt    completed clk_out periods since the last start
// -----------------------------------------------------------------------------
module freq_gen_module #(
  parameter int W = 32
) (
  input  logic         clk_base,
  input  logic         reset,
  input  logic         freq_wr,
  input  logic [W-1:0] freq_set,
  input  logic [W-1:0] freq_base,
  input  logic [W-1:0] burst_len,
  output logic         clk_out,
  output logic         busy,
  output logic         upd,
  output logic         err,
  output logic         done,
  output logic [W-1:0] per_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  // A write is usable only if the base clock is known and the requested
  // rate does not exceed half of it (clk_out can toggle at most once per cycle).
  function automatic logic wr_ok(input logic [W-1:0] fs, input logic [W-1:0] fb);
    logic [W:0] two_f;
    two_f = {fs, 1'b0};
    wr_ok = (fb != ZERO_W) && (two_f <= {1'b0, fb});
  endfunction

  // Registered state
  state_t       state_r;
  logic [W-1:0] acc_r;
  logic [W-1:0] f_act_r;
  logic [W-1:0] fb_act_r;
  logic [W-1:0] bl_act_r;
  logic [W-1:0] pend_f_r;
  logic [W-1:0] pend_fb_r;
  logic [W-1:0] pend_bl_r;
  logic         pend_vld_r;
  logic         clk_out_r;
  logic         busy_r;
  logic         upd_r;
  logic         err_r;
  logic         done_r;
  logic [W-1:0] per_cnt_r;

  // Next-state values
  state_t       state_s;
  logic [W-1:0] acc_s;
  logic [W-1:0] f_act_s;
  logic [W-1:0] fb_act_s;
  logic [W-1:0] bl_act_s;
  logic [W-1:0] pend_f_s;
  logic [W-1:0] pend_fb_s;
  logic [W-1:0] pend_bl_s;
  logic         pend_vld_s;
  logic         clk_out_s;
  logic         busy_s;
  logic         upd_s;
  logic         err_s;
  logic         done_s;
  logic [W-1:0] per_cnt_s;

  // Datapath helpers
  logic         wr_acc_s;
  logic [W+1:0] sum_s;
  logic         toggle_s;
  logic         boundary_s;
  logic [W-1:0] per_cnt_inc_s;
  logic         burst_end_s;

  // Accumulator step and period-boundary detection. The sum is kept two bits
  // wider than W so acc + 2*f can never overflow before the compare.
  always_comb begin
    sum_s         = {2'b00, acc_r} + {1'b0, f_act_r, 1'b0};
    toggle_s      = (sum_s >= {2'b00, fb_act_r});
    boundary_s    = (state_r == RUN) && toggle_s && clk_out_r;
    per_cnt_inc_s = per_cnt_r + ONE_W;
    wr_acc_s      = freq_wr && wr_ok(freq_set, freq_base);
  end

`ifdef FREQ_GEN_BURST_EN
  assign burst_end_s = boundary_s && (bl_act_r != ZERO_W) && (per_cnt_inc_s == bl_act_r);
  assign done        = done_r;
`else
  // Burst length is latched but has no effect; these bits only feed a sink.
  logic unused_burst_s;
  assign burst_end_s    = 1'b0;
  assign done           = 1'b0;
  assign unused_burst_s = ^{bl_act_r, done_r};
`endif

  // Next-state and output logic of the IDLE/RUN controller.
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    f_act_s    = f_act_r;
    fb_act_s   = fb_act_r;
    bl_act_s   = bl_act_r;
    pend_f_s   = pend_f_r;
    pend_fb_s  = pend_fb_r;
    pend_bl_s  = pend_bl_r;
    pend_vld_s = pend_vld_r;
    clk_out_s  = clk_out_r;
    per_cnt_s  = per_cnt_r;
    upd_s      = 1'b0;
    done_s     = 1'b0;
    err_s      = freq_wr && !wr_ok(freq_set, freq_base);

    // Accepted writes always land in the pending set first; last write wins.
    if (wr_acc_s) begin
      pend_f_s   = freq_set;
      pend_fb_s  = freq_base;
      pend_bl_s  = burst_len;
      pend_vld_s = 1'b1;
    end else begin
      pend_vld_s = pend_vld_r;
    end

    case (state_r)
      IDLE: begin
        clk_out_s = 1'b0;
        acc_s     = ZERO_W;
        if (wr_acc_s) begin
          // IDLE applies a write at once; nothing stays pending.
          pend_vld_s = 1'b0;
          upd_s      = 1'b1;
          if (freq_set != ZERO_W) begin
            f_act_s   = freq_set;
            fb_act_s  = freq_base;
            bl_act_s  = burst_len;
            per_cnt_s = ZERO_W;
            state_s   = RUN;
          end else begin
            state_s = IDLE;
          end
        end else if (pend_vld_r) begin
          // A write that arrived on the very boundary that stopped the
          // generator is honoured here instead of being lost.
          pend_vld_s = 1'b0;
          upd_s      = 1'b1;
          if (pend_f_r != ZERO_W) begin
            f_act_s   = pend_f_r;
            fb_act_s  = pend_fb_r;
            bl_act_s  = pend_bl_r;
            per_cnt_s = ZERO_W;
            state_s   = RUN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        // s < 2*fb_act, so one subtraction restores acc to [0, fb_act),
        // and the true difference always fits in W bits.
        if (toggle_s) begin
          acc_s     = sum_s[W-1:0] - fb_act_r;
          clk_out_s = ~clk_out_r;
        end else begin
          acc_s     = sum_s[W-1:0];
          clk_out_s = clk_out_r;
        end

        if (boundary_s) begin
          per_cnt_s = per_cnt_inc_s;
          if (burst_end_s) begin
            state_s    = IDLE;
            done_s     = 1'b1;
            pend_vld_s = 1'b0;
          end else if (pend_vld_r) begin
            // Apply the older pending set; a write in this same cycle has
            // already replaced the pending registers and waits for the next
            // boundary.
            upd_s      = 1'b1;
            pend_vld_s = wr_acc_s;
            if (pend_f_r == ZERO_W) begin
              state_s = IDLE;
            end else begin
              f_act_s  = pend_f_r;
              fb_act_s = pend_fb_r;
              bl_act_s = pend_bl_r;
              // Phase is kept, except when a smaller base would leave acc
              // outside [0, fb_act); restart the phase in that case.
              if (acc_s >= pend_fb_r) begin
                acc_s = ZERO_W;
              end else begin
                acc_s = acc_s;
              end
            end
          end else begin
            state_s = RUN;
          end
        end else begin
          per_cnt_s = per_cnt_r;
        end
      end

      default: begin
        state_s    = IDLE;
        acc_s      = ZERO_W;
        clk_out_s  = 1'b0;
        pend_vld_s = 1'b0;
      end
    endcase

    busy_s = (state_s == RUN);
  end

  // State and output registers; reset clears every output at once.
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      acc_r      <= ZERO_W;
      f_act_r    <= ZERO_W;
      fb_act_r   <= ZERO_W;
      bl_act_r   <= ZERO_W;
      pend_f_r   <= ZERO_W;
      pend_fb_r  <= ZERO_W;
      pend_bl_r  <= ZERO_W;
      pend_vld_r <= 1'b0;
      clk_out_r  <= 1'b0;
      busy_r     <= 1'b0;
      upd_r      <= 1'b0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      per_cnt_r  <= ZERO_W;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      f_act_r    <= f_act_s;
      fb_act_r   <= fb_act_s;
      bl_act_r   <= bl_act_s;
      pend_f_r   <= pend_f_s;
      pend_fb_r  <= pend_fb_s;
      pend_bl_r  <= pend_bl_s;
      pend_vld_r <= pend_vld_s;
      clk_out_r  <= clk_out_s;
      busy_r     <= busy_s;
      upd_r      <= upd_s;
      err_r      <= err_s;
      done_r     <= done_s;
      per_cnt_r  <= per_cnt_s;
    end
  end

  assign clk_out = clk_out_r;
  assign busy    = busy_r;
  assign upd     = upd_r;
  assign err     = err_r;
  assign per_cnt = per_cnt_r;

endmodule

// File: tb/tb_freq_gen_module.sv
// -----------------------------------------------------------------------------
// tb_freq_gen_module
//
// Directed, self-checking bench for freq_gen_module. Inputs change and outputs
// are sampled on the falling edge of clk_base. After drive_wr returns, the
// outputs reflect the capturing rising edge ("edge t"); each further falling
// edge adds one RUN cycle k.
// -----------------------------------------------------------------------------
module tb_freq_gen_module;

  localparam int W = 32;

  logic         clk_base = 1'b0;
  logic         reset;
  logic         freq_wr;
  logic [W-1:0] freq_set;
  logic [W-1:0] freq_base;
  logic [W-1:0] burst_len;
  logic         clk_out;
  logic         busy;
  logic         upd;
  logic         err;
  logic         done;
  logic [W-1:0] per_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_base = ~clk_base;

  freq_gen_module #(.W(W)) dut (
    .clk_base  (clk_base),
    .reset     (reset),
    .freq_wr   (freq_wr),
    .freq_set  (freq_set),
    .freq_base (freq_base),
    .burst_len (burst_len),
    .clk_out   (clk_out),
    .busy      (busy),
    .upd       (upd),
    .err       (err),
    .done      (done),
    .per_cnt   (per_cnt)
  );

  // Called on a falling edge; returns on the falling edge after the write edge.
  task automatic drive_wr(input logic [W-1:0] fs, input logic [W-1:0] fb, input logic [W-1:0] bl);
    freq_set  = fs;
    freq_base = fb;
    burst_len = bl;
    freq_wr   = 1'b1;
    @(negedge clk_base);
    freq_wr   = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk_base);
    reset = 1'b0;
    @(negedge clk_base);
  endtask

  task automatic test_reset;
    reset = 1'b1; freq_wr = 1'b0;
    @(negedge clk_base);
    @(negedge clk_base);
    n_cmp++; if ({clk_out, busy, upd, err, done} !== 5'b00000) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {clk_out, busy, upd, err, done}); end
    n_cmp++; if (per_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_per_cnt: got %0d want 0", per_cnt); end
    reset = 1'b0;
    @(negedge clk_base);
    n_cmp++; if ({clk_out, busy, upd, err, done} !== 5'b00000) begin n_bad++; $display("FAIL post_reset_flags: got %b want 00000", {clk_out, busy, upd, err, done}); end
  endtask

  task automatic test_basic_period;
    logic exp_clk;
    do_reset();
    drive_wr(32'd10, 32'd100, 32'd0);
    n_cmp++; if ({busy, upd, err, clk_out} !== 4'b1100) begin n_bad++; $display("FAIL basic_start: got busy/upd/err/clk=%b want 1100", {busy, upd, err, clk_out}); end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_base);
      exp_clk = ((k / 5) % 2) == 1;
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL basic_clk k=%0d: got %b want %b", k, clk_out, exp_clk); end
      if (k == 1) begin
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL basic_upd_pulse: got %b want 0", upd); end
      end
      if (k == 10) begin
        n_cmp++; if (per_cnt !== 32'd1) begin n_bad++; $display("FAIL basic_per_cnt10: got %0d want 1", per_cnt); end
      end
    end
    n_cmp++; if (per_cnt !== 32'd3) begin n_bad++; $display("FAIL basic_per_cnt30: got %0d want 3", per_cnt); end
  endtask

  // Continues from test_basic_period: RUN cycle 30 has just completed.
  task automatic test_stop;
    drive_wr(32'd0, 32'd100, 32'd0);
    n_cmp++; if ({busy, upd} !== 2'b10) begin n_bad++; $display("FAIL stop_pending: got busy/upd=%b want 10", {busy, upd}); end
    for (int k = 32; k <= 40; k++) begin
      @(negedge clk_base);
      if (k == 39) begin
        n_cmp++; if ({busy, clk_out} !== 2'b11) begin n_bad++; $display("FAIL stop_before: got busy/clk=%b want 11", {busy, clk_out}); end
      end
      if (k == 40) begin
        n_cmp++; if ({busy, upd, clk_out} !== 3'b010) begin n_bad++; $display("FAIL stop_boundary: got busy/upd/clk=%b want 010", {busy, upd, clk_out}); end
        n_cmp++; if (per_cnt !== 32'd4) begin n_bad++; $display("FAIL stop_per_cnt: got %0d want 4", per_cnt); end
      end
    end
    @(negedge clk_base);
    n_cmp++; if ({busy, upd, clk_out} !== 3'b000) begin n_bad++; $display("FAIL stop_idle: got busy/upd/clk=%b want 000", {busy, upd, clk_out}); end
    drive_wr(32'd0, 32'd100, 32'd0);
    n_cmp++; if ({busy, upd, err} !== 3'b010) begin n_bad++; $display("FAIL idle_zero_write: got busy/upd/err=%b want 010", {busy, upd, err}); end
  endtask

  task automatic test_half_rate_reject;
    logic exp_clk;
    do_reset();
    drive_wr(32'd50, 32'd100, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_base);
      exp_clk = (k % 2) == 1;
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL half_clk k=%0d: got %b want %b", k, clk_out, exp_clk); end
    end
    drive_wr(32'd51, 32'd100, 32'd0);
    n_cmp++; if ({err, upd, clk_out} !== 3'b101) begin n_bad++; $display("FAIL reject_51: got err/upd/clk=%b want 101", {err, upd, clk_out}); end
    @(negedge clk_base);
    n_cmp++; if ({err, busy, clk_out} !== 3'b010) begin n_bad++; $display("FAIL reject_after: got err/busy/clk=%b want 010", {err, busy, clk_out}); end
    drive_wr(32'd1, 32'd0, 32'd0);
    n_cmp++; if ({err, clk_out} !== 2'b11) begin n_bad++; $display("FAIL reject_fb0: got err/clk=%b want 11", {err, clk_out}); end
    for (int k = 10; k <= 12; k++) begin
      @(negedge clk_base);
    end
    n_cmp++; if ({err, upd, busy, clk_out} !== 4'b0010) begin n_bad++; $display("FAIL reject_unchanged: got err/upd/busy/clk=%b want 0010", {err, upd, busy, clk_out}); end
  endtask

  task automatic test_fractional;
    logic [9:0] pat;
    pat = 10'b0100110110;
    do_reset();
    drive_wr(32'd30, 32'd100, 32'd0);
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk_base);
      if (k <= 10) begin
        n_cmp++; if (clk_out !== pat[k-1]) begin n_bad++; $display("FAIL frac_clk k=%0d: got %b want %b", k, clk_out, pat[k-1]); end
      end
      if (k == 100) begin
        n_cmp++; if (per_cnt !== 32'd30) begin n_bad++; $display("FAIL frac_per_cnt100: got %0d want 30", per_cnt); end
      end
    end
    n_cmp++; if (per_cnt !== 32'd300) begin n_bad++; $display("FAIL frac_per_cnt1000: got %0d want 300", per_cnt); end
  endtask

  task automatic test_mid_run_change;
    logic exp_clk;
    do_reset();
    drive_wr(32'd10, 32'd100, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_base);
    end
    drive_wr(32'd25, 32'd100, 32'd0);
    n_cmp++; if ({upd, clk_out} !== 2'b01) begin n_bad++; $display("FAIL mid_pending: got upd/clk=%b want 01", {upd, clk_out}); end
    for (int k = 8; k <= 20; k++) begin
      @(negedge clk_base);
      exp_clk = (k < 10) ? 1'b1 : (((k - 10) / 2) % 2) == 1;
      n_cmp++; if (clk_out !== exp_clk) begin n_bad++; $display("FAIL mid_clk k=%0d: got %b want %b", k, clk_out, exp_clk); end
      if (k == 10) begin
        n_cmp++; if ({upd, per_cnt} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL mid_apply: got upd=%b per_cnt=%0d want upd=1 per_cnt=1", upd, per_cnt); end
      end
      if (k == 18) begin
        n_cmp++; if (per_cnt !== 32'd3) begin n_bad++; $display("FAIL mid_per_cnt: got %0d want 3", per_cnt); end
      end
    end
    // clk_out is high here (k = 20); reset must clear outputs immediately.
    reset = 1'b1;
    #1;
    n_cmp++; if ({clk_out, busy, upd, err, done} !== 5'b00000) begin n_bad++; $display("FAIL async_reset_flags: got %b want 00000", {clk_out, busy, upd, err, done}); end
    n_cmp++; if (per_cnt !== 32'd0) begin n_bad++; $display("FAIL async_reset_per_cnt: got %0d want 0", per_cnt); end
    @(negedge clk_base);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive_wr(32'd10, 32'd100, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_base);
    end
    drive_wr(32'd25, 32'd100, 32'd0);
    n_cmp++; if ({upd, clk_out, per_cnt} !== {1'b0, 1'b0, 32'd1}) begin n_bad++; $display("FAIL b2b_boundary_write: got upd=%b clk=%b per_cnt=%0d want 0 0 1", upd, clk_out, per_cnt); end
    @(negedge clk_base);
    drive_wr(32'd20, 32'd100, 32'd0);
    for (int k = 13; k <= 25; k++) begin
      @(negedge clk_base);
      if (k == 15 || k == 19 || k == 23) begin
        n_cmp++; if (clk_out !== 1'b1) begin n_bad++; $display("FAIL b2b_high k=%0d: got %b want 1", k, clk_out); end
      end
      if (k == 19) begin
        n_cmp++; if (upd !== 1'b0) begin n_bad++; $display("FAIL b2b_no_early_upd: got %b want 0", upd); end
      end
      if (k == 20) begin
        n_cmp++; if ({upd, clk_out, per_cnt} !== {1'b1, 1'b0, 32'd2}) begin n_bad++; $display("FAIL b2b_apply: got upd=%b clk=%b per_cnt=%0d want 1 0 2", upd, clk_out, per_cnt); end
      end
      if (k == 22) begin
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL b2b_last_wins: got %b want 0", clk_out); end
      end
    end
    n_cmp++; if ({clk_out, per_cnt} !== {1'b0, 32'd3}) begin n_bad++; $display("FAIL b2b_new_period: got clk=%b per_cnt=%0d want 0 3", clk_out, per_cnt); end
  endtask

  task automatic test_burst;
    do_reset();
    drive_wr(32'd10, 32'd100, 32'd3);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_base);
`ifdef FREQ_GEN_BURST_EN
      if (k == 29) begin
        n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL burst_before: got busy/done=%b want 10", {busy, done}); end
      end
      if (k == 30) begin
        n_cmp++; if ({done, busy, clk_out, per_cnt} !== {3'b100, 32'd3}) begin n_bad++; $display("FAIL burst_done: got done/busy/clk=%b per_cnt=%0d want 100 3", {done, busy, clk_out}, per_cnt); end
      end
      if (k == 31 || k == 35) begin
        n_cmp++; if ({done, busy, clk_out} !== 3'b000) begin n_bad++; $display("FAIL burst_after k=%0d: got %b want 000", k, {done, busy, clk_out}); end
      end
`else
      if (k == 30) begin
        n_cmp++; if ({done, busy, per_cnt} !== {2'b01, 32'd3}) begin n_bad++; $display("FAIL burst_ignored30: got done/busy=%b per_cnt=%0d want 01 3", {done, busy}, per_cnt); end
      end
      if (k == 40) begin
        n_cmp++; if ({done, busy, per_cnt} !== {2'b01, 32'd4}) begin n_bad++; $display("FAIL burst_ignored40: got done/busy=%b per_cnt=%0d want 01 4", {done, busy}, per_cnt); end
      end
`endif
    end
  endtask

  initial begin
    reset     = 1'b1;
    freq_wr   = 1'b0;
    freq_set  = 32'd0;
    freq_base = 32'd0;
    burst_len = 32'd0;
    test_reset();
    test_basic_period();
    test_stop();
    test_half_rate_reject();
    test_fractional();
    test_mid_run_change();
    test_back_to_back();
    test_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
